// File: rtl/lsu_regport_if.sv
// Request and data-bus signal bundle for the lsu_regport load/store unit.
// The slave modport is the unit's view. The master modport is the core-plus-bus environment's view.
interface lsu_regport_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [REG_AW-1:0] req_rd;
  logic [REG_AW-1:0] req_rs2;
  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_rd, req_rs2,
    input  req_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_rd, req_rs2,
    output req_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_regport.sv
// Single-outstanding load/store unit between the register-file memory ports and the data bus.
// A store reads rs2 and then writes the bus. A load reads the bus, then aligns and extends the data and writes it back.
module lsu_regport #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  lsu_regport_if.slave      io_bus,
  output logic [REG_AW-1:0] o_mem_read_addr,
  input  logic [XLEN-1:0]   i_mem_read_data,
  input  logic              i_write_en,
  input  logic [REG_AW-1:0] i_write_addr,
  input  logic [XLEN-1:0]   i_write_data,
  output logic              o_mem_write_en,
  output logic [REG_AW-1:0] o_mem_write_addr,
  output logic [XLEN-1:0]   o_mem_write_data,
  output logic              o_fault,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDREG = 2'd1,
    BUS   = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_mem_read_addr;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [XLEN-1:0]   r_bus_addr;
  logic [XLEN-1:0]   r_bus_wdata;
  logic [3:0]        r_bus_wstrb;
  logic              r_mem_write_en;
  logic [REG_AW-1:0] r_mem_write_addr;
  logic [XLEN-1:0]   r_mem_write_data;
  logic              r_fault;

  logic [XLEN-1:0]   w_store_data;
  logic [XLEN-1:0]   w_wdata;
  logic [3:0]        w_wstrb;
  logic [XLEN-1:0]   w_load_data;
  logic              w_bad_op;
  logic              w_wb_blocked;

  function automatic logic is_illegal(input logic store, input logic [2:0] f3);
    logic bad;
    if (store) begin
      bad = (f3 > 3'b010);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  assign w_bad_op     = is_illegal(io_bus.req_store, io_bus.req_funct3) ||
                        is_misaligned(io_bus.req_funct3, io_bus.req_addr[1:0]);
  assign w_load_data  = load_extend(r_funct3, r_addr_lo, io_bus.bus_rdata);
  // The register file lets the core port win, so a nonzero core write means ours did not land.
  assign w_wb_blocked = i_write_en && (i_write_addr != {REG_AW{1'b0}});

  // Store-data source: x0 reads as zero, and an in-flight core write to rs2 is bypassed.
  always_comb begin
    w_store_data = i_mem_read_data;
    if (r_mem_read_addr == {REG_AW{1'b0}}) begin
      w_store_data = {XLEN{1'b0}};
    end else if (i_write_en && (i_write_addr == r_mem_read_addr)) begin
      w_store_data = i_write_data;
    end else begin
      w_store_data = i_mem_read_data;
    end
  end

  // Lane replication and byte enables for the store width.
  always_comb begin
    w_wdata = w_store_data;
    w_wstrb = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin
        w_wdata = {4{w_store_data[7:0]}};
        w_wstrb = 4'b0001 << r_addr_lo;
      end
      2'b01: begin
        w_wdata = {2{w_store_data[15:0]}};
        w_wstrb = 4'b0011 << {r_addr_lo[1], 1'b0};
      end
      default: begin
        w_wdata = w_store_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Control FSM with registered bus, writeback and fault outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_store          <= 1'b0;
      r_funct3         <= 3'b000;
      r_addr_lo        <= 2'b00;
      r_rd             <= {REG_AW{1'b0}};
      r_mem_read_addr  <= {REG_AW{1'b0}};
      r_bus_req        <= 1'b0;
      r_bus_we         <= 1'b0;
      r_bus_addr       <= {XLEN{1'b0}};
      r_bus_wdata      <= {XLEN{1'b0}};
      r_bus_wstrb      <= 4'b0000;
      r_mem_write_en   <= 1'b0;
      r_mem_write_addr <= {REG_AW{1'b0}};
      r_mem_write_data <= {XLEN{1'b0}};
      r_fault          <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.req_valid) begin
            r_store   <= io_bus.req_store;
            r_funct3  <= io_bus.req_funct3;
            r_addr_lo <= io_bus.req_addr[1:0];
            r_rd      <= io_bus.req_rd;
            if (w_bad_op) begin
              r_fault <= 1'b1;
            end else if (io_bus.req_store) begin
              r_mem_read_addr <= io_bus.req_rs2;
              r_bus_addr      <= {io_bus.req_addr[XLEN-1:2], 2'b00};
              r_state         <= RDREG;
            end else begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= {io_bus.req_addr[XLEN-1:2], 2'b00};
              r_bus_wdata <= {XLEN{1'b0}};
              r_bus_wstrb <= 4'b0000;
              r_state     <= BUS;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RDREG: begin
          r_bus_req       <= 1'b1;
          r_bus_we        <= 1'b1;
          r_bus_wdata     <= w_wdata;
          r_bus_wstrb     <= w_wstrb;
          r_mem_read_addr <= {REG_AW{1'b0}};
          r_state         <= BUS;
        end
        BUS: begin
          if (io_bus.bus_ack) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= {XLEN{1'b0}};
            r_bus_wdata <= {XLEN{1'b0}};
            r_bus_wstrb <= 4'b0000;
            if (r_store || (r_rd == {REG_AW{1'b0}})) begin
              r_state <= IDLE;
            end else begin
              r_mem_write_en   <= 1'b1;
              r_mem_write_addr <= r_rd;
              r_mem_write_data <= w_load_data;
              r_state          <= WB;
            end
          end else begin
            r_state <= BUS;
          end
        end
        WB: begin
          if (w_wb_blocked) begin
            r_state <= WB;
          end else begin
            r_mem_write_en   <= 1'b0;
            r_mem_write_addr <= {REG_AW{1'b0}};
            r_mem_write_data <= {XLEN{1'b0}};
            r_state          <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.req_ready = (r_state == IDLE);
  assign io_bus.bus_req   = r_bus_req;
  assign io_bus.bus_we    = r_bus_we;
  assign io_bus.bus_addr  = r_bus_addr;
  assign io_bus.bus_wdata = r_bus_wdata;
  assign io_bus.bus_wstrb = r_bus_wstrb;
  assign o_mem_read_addr  = r_mem_read_addr;
  assign o_mem_write_en   = r_mem_write_en;
  assign o_mem_write_addr = r_mem_write_addr;
  assign o_mem_write_data = r_mem_write_data;
  assign o_fault          = r_fault;
  assign o_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_lsu_regport.sv
// Directed-vector bench for lsu_regport. Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_regport;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] mem_read_addr;
  logic [XLEN-1:0]   mem_read_data;
  logic              write_en;
  logic [REG_AW-1:0] write_addr;
  logic [XLEN-1:0]   write_data;
  logic              mem_write_en;
  logic [REG_AW-1:0] mem_write_addr;
  logic [XLEN-1:0]   mem_write_data;
  logic              fault;
  logic              busy;
  logic [XLEN-1:0]   rf [32];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lsu_regport_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bif ();

  lsu_regport #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .io_bus           (bif.slave),
    .o_mem_read_addr  (mem_read_addr),
    .i_mem_read_data  (mem_read_data),
    .i_write_en       (write_en),
    .i_write_addr     (write_addr),
    .i_write_data     (write_data),
    .o_mem_write_en   (mem_write_en),
    .o_mem_write_addr (mem_write_addr),
    .o_mem_write_data (mem_write_data),
    .o_fault          (fault),
    .o_busy           (busy)
  );

  assign mem_read_data = rf[mem_read_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [4:0] rd, input logic [4:0] rs2);
    bif.req_valid  = 1'b1;
    bif.req_store  = st;
    bif.req_funct3 = f3;
    bif.req_addr   = a;
    bif.req_rd     = rd;
    bif.req_rs2    = rs2;
    @(negedge clk);
    bif.req_valid  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_baddr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b0, f3, a, rd, 5'd0);
    check({tag, "_req"}, {31'd0, bif.bus_req}, 32'd1);
    check({tag, "_baddr"}, bif.bus_addr, exp_baddr);
    check({tag, "_wstrb"}, {28'd0, bif.bus_wstrb}, 32'd0);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = rdata;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check({tag, "_mwe"}, {31'd0, mem_write_en}, 32'd1);
    check({tag, "_mwaddr"}, {27'd0, mem_write_addr}, {27'd0, rd});
    check({tag, "_data"}, mem_write_data, exp);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bif.req_ready}, 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp_baddr, input logic [4:0] rs2, input int delay,
                          input logic byp, input logic [31:0] byp_data,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    issue(1'b1, f3, a, 5'd0, rs2);
    check({tag, "_rdaddr"}, {27'd0, mem_read_addr}, {27'd0, rs2});
    check({tag, "_noreq"}, {31'd0, bif.bus_req}, 32'd0);
    if (byp) begin
      write_en   = 1'b1;
      write_addr = rs2;
      write_data = byp_data;
    end else begin
      write_en = 1'b0;
    end
    @(negedge clk);
    write_en = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      check({tag, "_req"}, {31'd0, bif.bus_req}, 32'd1);
      check({tag, "_we"}, {31'd0, bif.bus_we}, 32'd1);
      check({tag, "_baddr"}, bif.bus_addr, exp_baddr);
      check({tag, "_wdata"}, bif.bus_wdata, exp_wdata);
      check({tag, "_wstrb"}, {28'd0, bif.bus_wstrb}, {28'd0, exp_wstrb});
      if (i == delay) bif.bus_ack = 1'b1;
      @(negedge clk);
    end
    bif.bus_ack = 1'b0;
    check({tag, "_done_req"}, {31'd0, bif.bus_req}, 32'd0);
    check({tag, "_ready"}, {31'd0, bif.req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0000 + i;
    rf[0] = 32'hFFFF_FFFF;
    rf[7] = 32'h1234_5678;
    rst_n = 1'b0;
    write_en = 1'b0; write_addr = 5'd0; write_data = 32'd0;
    bif.req_valid = 1'b0; bif.req_store = 1'b0; bif.req_funct3 = 3'b000;
    bif.req_addr = 32'd0; bif.req_rd = 5'd0; bif.req_rs2 = 5'd0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bif.req_ready}, 32'd1);
    check("rst_busreq", {31'd0, bif.bus_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_mwe", {31'd0, mem_write_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads with the ack in the first bus cycle
    do_load("lw",  3'b010, 32'h0000_0100, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h0000_0103, 32'h0000_0100, 5'd6, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h0000_0100, 5'd6, 32'h80FF_FFFF, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_0102, 32'h0000_0100, 5'd8, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0102, 32'h0000_0100, 5'd8, 32'h8001_1234, 32'h0000_8001);
    do_load("lb1", 3'b000, 32'h0000_0101, 32'h0000_0100, 5'd9, 32'h1234_7F00, 32'h0000_007F);

    // Stores
    do_store("sb", 3'b000, 32'h0000_0021, 32'h0000_0020, 5'd7, 3, 1'b0, 32'd0, 32'h7878_7878, 4'b0010);
    do_store("sh", 3'b001, 32'h0000_0022, 32'h0000_0020, 5'd7, 0, 1'b0, 32'd0, 32'h5678_5678, 4'b1100);
    do_store("sw_byp", 3'b010, 32'h0000_0040, 32'h0000_0040, 5'd7, 1, 1'b1, 32'hAAAA_5555,
             32'hAAAA_5555, 4'b1111);
    do_store("sw_x0", 3'b010, 32'h0000_0044, 32'h0000_0044, 5'd0, 0, 1'b0, 32'd0, 32'h0000_0000, 4'b1111);

    // Writeback blocked by the core port for two cycles
    issue(1'b0, 3'b010, 32'h0000_0010, 5'd9, 5'd0);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    write_en = 1'b1; write_addr = 5'd3; write_data = 32'h3333_3333;
    check("wbs_mwe1", {31'd0, mem_write_en}, 32'd1);
    @(negedge clk);
    check("wbs_mwe2", {31'd0, mem_write_en}, 32'd1);
    @(negedge clk);
    write_en = 1'b0;
    check("wbs_mwe3", {31'd0, mem_write_en}, 32'd1);
    check("wbs_data", mem_write_data, 32'h0BAD_CAFE);
    check("wbs_nrdy", {31'd0, bif.req_ready}, 32'd0);
    @(negedge clk);
    check("wbs_mwe4", {31'd0, mem_write_en}, 32'd0);
    check("wbs_ready", {31'd0, bif.req_ready}, 32'd1);

    // Load to x0 performs no writeback
    issue(1'b0, 3'b010, 32'h0000_0010, 5'd0, 5'd0);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("ldx0_mwe", {31'd0, mem_write_en}, 32'd0);
    check("ldx0_ready", {31'd0, bif.req_ready}, 32'd1);

    // Faults
    issue(1'b0, 3'b010, 32'h0000_0102, 5'd5, 5'd0);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_busreq", {31'd0, bif.bus_req}, 32'd0);
    check("mis_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("mis_pulse", {31'd0, fault}, 32'd0);
    issue(1'b0, 3'b011, 32'h0000_0100, 5'd5, 5'd0);
    check("ill_ld_fault", {31'd0, fault}, 32'd1);
    @(negedge clk);
    issue(1'b1, 3'b100, 32'h0000_0100, 5'd0, 5'd7);
    check("ill_st_fault", {31'd0, fault}, 32'd1);
    check("ill_st_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // Reset while the bus transaction is pending, then a stale ack
    issue(1'b0, 3'b010, 32'h0000_0200, 5'd4, 5'd0);
    check("rb_req", {31'd0, bif.bus_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rb_busreq", {31'd0, bif.bus_req}, 32'd0);
    check("rb_busy", {31'd0, busy}, 32'd0);
    check("rb_ready", {31'd0, bif.req_ready}, 32'd1);
    rst_n = 1'b1;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("stale_mwe", {31'd0, mem_write_en}, 32'd0);
    check("stale_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("stale_mwe2", {31'd0, mem_write_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/lsu_regport.md
Name: lsu_regport

Overview:
- Load/store unit on the memory side of the register file's memory port pair.
- Stores: reads store data (rs2) through the mem_read port, then issues a bus write.
- Loads: issue a bus read, align and extend the result, write it back through the mem_write port.
- One request in flight. Sits beside the execute stage, between the core and the data bus.

Parameters:
- XLEN, 32, data/address width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  execute offers a memory op.
- req_ready  out  1  unit accepts an op this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width/sign code.
- req_addr  in  XLEN  effective byte address.
- req_rd  in  REG_AW  load destination.
- req_rs2  in  REG_AW  store data source.
- mem_read_addr  out  REG_AW  register file store-data read address.
- mem_read_data  in  XLEN  register file store-data value (combinational).
- write_en  in  1  core writeback port enable (observed for bypass/stall).
- write_addr  in  REG_AW  core writeback address.
- write_data  in  XLEN  core writeback data.
- mem_write_en  out  1  load writeback request.
- mem_write_addr  out  REG_AW  load destination.
- mem_write_data  out  XLEN  extended load data.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write.
- bus_addr  out  XLEN  word-aligned address.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_wstrb  out  4  byte enables.
- bus_ack  in  1  transaction complete; rdata valid.
- bus_rdata  in  XLEN  read word.
- fault  out  1  one-cycle pulse: misaligned access or illegal funct3.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - Any bus transaction in progress is abandoned: bus_req drops on that edge and a late bus_ack is ignored.
- States:
  - IDLE
    - req_ready=1.
    - On req_valid, latch store, funct3, addr, rd, rs2.
    - If the op is illegal or misaligned: pulse fault next cycle, stay IDLE, no bus access.
    - Illegal: load funct3 not in {000, 001, 010, 100, 101}; store funct3 not in {000, 001, 010}.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
    - Otherwise go to RDREG for a store, or BUS for a load.
  - RDREG
    - Store only, one cycle; mem_read_addr = latched rs2.
    - Capture store data = write_data if (write_en && write_addr==rs2 && rs2!=0), else mem_read_data. rs2==0 yields 0.
    - Go to BUS.
  - BUS
    - bus_req=1; bus_we, bus_addr, bus_wdata, bus_wstrb are held stable until bus_ack.
    - On bus_ack, a store goes to IDLE. A load registers its extended data and goes to WB; if rd==0 it goes to IDLE with no writeback.
    - No timeout.
  - WB
    - mem_write_en=1, with mem_write_addr and mem_write_data held.
    - The register file gives write_en priority over mem_write_en, so the write has not landed if (write_en && write_addr!=0) this cycle. In that case stay in WB.
    - Otherwise the write lands at this edge; go to IDLE.
- Bus formatting:
  - bus_addr = {addr[XLEN-1:2], 2'b00}.
  - SB: wdata = byte x4, wstrb = 0001 << addr[1:0].
  - SH: wdata = half x2, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction: byte/half selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Latency, counted from the accept edge:
  - Store: bus_req is high from cycle 2 (after RDREG); unit is free the cycle after the ack cycle.
  - Load with same-cycle ack: bus_req in cycle 1, mem_write_en in cycle 2, register written at the end of cycle 2; req_ready in cycle 3.
- A back-to-back request is accepted only in IDLE. req_ready is combinational from the state only.

Test Plan:
- LW addr 0x100, rd=5, bus_rdata=0xDEADBEEF, ack in the first BUS cycle -> bus_addr=0x100 and wstrb=0 in cycle 1; mem_write_en=1, addr=5, data=0xDEADBEEF in cycle 2; req_ready in cycle 3.
- LB addr 0x103, rdata=0x80FFFFFF -> data 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102, rdata=0x8001xxxx -> 0xFFFF8001.
- SB addr 0x21, rs2=7 holding 0x12345678 -> wdata=0x78787878, wstrb=0010. SH addr 0x22 -> wdata=0x56785678, wstrb=1100. Ack delayed 3 cycles -> bus signals stable for all 4 cycles.
- Store in RDREG while write_en=1, write_addr=7, write_data=0xAAAA5555 -> wdata built from 0xAAAA5555, not from mem_read_data.
- Load in WB with write_en=1, write_addr=3 for 2 cycles -> mem_write_en held 3 cycles, written on the third; rd=0 load -> no mem_write_en.
- LW addr 0x102 -> fault pulse, no bus_req. Funct3=011 -> fault. rst low during BUS -> bus_req=0, busy=0, req_ready=1 next cycle; a later stale ack has no effect.
